// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: power-up/init sequencer and round-robin two-port arbiter
// for an 8-bit, write-only HD44780-style LCD. It owns all EN timing.
module lcd_bus_arbiter #(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 50_000,
    parameter int HOLD_CYC  = 50_000,
    parameter int LONG_CYC  = 100_000,
    parameter int PWRUP_CYC = 750_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    typedef enum logic [2:0] {PWRUP, IDLE, SETUP, PULSE, HOLD} stateT;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } xferT;

    stateT       state;
    logic [31:0] cnt;
    logic [1:0]  initIdx;
    logic        last;      // 1: requester 1 was granted most recently
    logic        pick0;
    logic        isLong;
    xferT        sel;

    // Fixed init sequence: 8-bit/2-line, display on, clear, entry mode
    function automatic logic [7:0] initByte(input logic [1:0] idx);
        case (idx)
            2'd0:    initByte = 8'h38;
            2'd1:    initByte = 8'h0C;
            2'd2:    initByte = 8'h01;
            default: initByte = 8'h06;
        endcase
    endfunction

    assign lcd_rw = 1'b0;

    // Grant choice: lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        pick0    = req0 && (!req1 || last);
        sel.rs   = pick0 ? rs0 : rs1;
        sel.data = pick0 ? data0 : data1;
    end

    // Clear/home commands need the long post-write wait
    always_comb begin
        isLong = !lcd_rs && (lcd_data[7:2] == 6'd0) && (lcd_data[1:0] != 2'd0);
    end

    // Sequencer FSM; every state loads cnt on entry and leaves when it hits zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= PWRUP;
            cnt       <= 32'(PWRUP_CYC - 1);
            initIdx   <= 2'd0;
            last      <= 1'b1;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
            lcd_data  <= 8'h00;
            lcd_rs    <= 1'b0;
            lcd_en    <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                PWRUP: begin
                    if (cnt == 32'd0) begin
                        initIdx  <= 2'd0;
                        lcd_data <= initByte(2'd0);
                        lcd_rs   <= 1'b0;
                        state    <= SETUP;
                        cnt      <= 32'(SETUP_CYC - 1);
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                IDLE: begin
                    if (init_done && (req0 || req1)) begin
                        ack0     <= pick0;
                        ack1     <= !pick0;
                        last     <= !pick0;
                        lcd_data <= sel.data;
                        lcd_rs   <= sel.rs;
                        busy     <= 1'b1;
                        state    <= SETUP;
                        cnt      <= 32'(SETUP_CYC - 1);
                    end
                end
                SETUP: begin
                    if (cnt == 32'd0) begin
                        lcd_en <= 1'b1;
                        state  <= PULSE;
                        cnt    <= 32'(EN_CYC - 1);
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                PULSE: begin
                    if (cnt == 32'd0) begin
                        lcd_en <= 1'b0;
                        state  <= HOLD;
                        cnt    <= isLong ? 32'(LONG_CYC - 1) : 32'(HOLD_CYC - 1);
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 32'd0) begin
                        if (!init_done && initIdx != 2'd3) begin
                            initIdx  <= initIdx + 2'd1;
                            lcd_data <= initByte(initIdx + 2'd1);
                            lcd_rs   <= 1'b0;
                            state    <= SETUP;
                            cnt      <= 32'(SETUP_CYC - 1);
                        end else begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                            cnt       <= 32'd0;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: begin
                    state  <= PWRUP;
                    cnt    <= 32'(PWRUP_CYC - 1);
                    lcd_en <= 1'b0;
                    busy   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with short timing parameters.
module tb_lcd_bus_arbiter;

    localparam int S = 2, E = 4, H = 6, L = 20, P = 10;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, rs0 = 1'b0, rs1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       ack0, ack1, busy, init_done, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    lcd_bus_arbiter #(
        .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .LONG_CYC(L), .PWRUP_CYC(P)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
        .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .init_done(init_done),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: EN edges, acks, init_done rise, data stability while EN high
    int         riseC[$], fallC[$], ackC[$], ackId[$];
    logic [7:0] riseD[$];
    logic       riseR[$];
    int         idRiseC = -1;
    int         enBad = 0;
    logic       enPrev = 1'b0, idPrev = 1'b0, curR = 1'b0;
    logic [7:0] curD = 8'h00;

    always @(negedge clk) begin
        enPrev <= lcd_en;
        idPrev <= init_done;
        if (lcd_en && !enPrev) begin
            riseC.push_back(cyc);
            riseD.push_back(lcd_data);
            riseR.push_back(lcd_rs);
            curD <= lcd_data;
            curR <= lcd_rs;
        end
        if (!lcd_en && enPrev) fallC.push_back(cyc);
        if (lcd_en && enPrev && (lcd_data != curD || lcd_rs != curR)) enBad <= enBad + 1;
        if (ack0) begin ackC.push_back(cyc); ackId.push_back(0); end
        if (ack1) begin ackC.push_back(cyc); ackId.push_back(1); end
        if (init_done && !idPrev) idRiseC <= cyc;
    end

    int nCmp = 0, nBad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clrMon();
        riseC.delete(); fallC.delete(); riseD.delete(); riseR.delete();
        ackC.delete(); ackId.delete();
    endtask

    task automatic waitAck(input string tag, input int lim, output int id, output int c);
        bit seen = 1'b0;
        id = -1; c = -1;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                seen = 1'b1;
                id   = ack1 ? 1 : 0;
                c    = cyc;
            end
        end
        chk({tag, "/ackSeen"}, 32'(seen), 1);
    endtask

    task automatic waitIdle(input string tag, output int c);
        bit seen = 1'b0;
        c = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (!busy) begin seen = 1'b1; c = cyc; end
        end
        chk({tag, "/idleSeen"}, 32'(seen), 1);
    endtask

    task automatic waitInit(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (init_done) seen = 1'b1;
        end
        chk({tag, "/initSeen"}, 32'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, id, c, b;
        logic [7:0] rom [4];
        int gap [3];
        bit enSeen;
        rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h01; rom[3] = 8'h06;
        gap[0] = H + S; gap[1] = H + S; gap[2] = L + S;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst/lcd_en", 32'(lcd_en), 0);
        chk("rst/lcd_rs", 32'(lcd_rs), 0);
        chk("rst/lcd_data", 32'(lcd_data), 0);
        chk("rst/lcd_rw", 32'(lcd_rw), 0);
        chk("rst/ack", 32'({ack1, ack0}), 0);
        chk("rst/busy", 32'(busy), 1);
        chk("rst/init_done", 32'(init_done), 0);

        // Init sequence
        clrMon();
        r0 = cyc;
        rst_n = 1'b1;
        waitInit("init");
        repeat (2) @(negedge clk);
        chk("init/pulses", riseC.size(), 4);
        if (riseC.size() == 4 && fallC.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("init/data", 32'(riseD[i]), 32'(rom[i]));
                chk("init/rs", 32'(riseR[i]), 0);
                chk("init/enWidth", fallC[i] - riseC[i], E);
            end
            for (int i = 0; i < 3; i++) chk("init/gap", riseC[i+1] - fallC[i], gap[i]);
            chk("init/firstRise", riseC[0] - r0, P + S);
            chk("init/lastHold", idRiseC - fallC[3], H);
        end
        chk("init/doneTime", idRiseC - r0, 72);
        chk("init/noAck", ackC.size(), 0);

        // Tie and round robin: 0,1,0,1
        clrMon();
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h42;
        for (int k = 0; k < 4; k++) begin
            waitAck("rr", 100, id, c);
            chk("rr/grant", 32'(id), 32'(k % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        waitIdle("rr", b);
        repeat (2) @(negedge clk);
        chk("rr/pulses", riseC.size(), 4);
        if (riseC.size() == 4) begin
            chk("rr/d0", 32'(riseD[0]), 32'h41);
            chk("rr/d1", 32'(riseD[1]), 32'h42);
            chk("rr/d2", 32'(riseD[2]), 32'h41);
            chk("rr/d3", 32'(riseD[3]), 32'h42);
        end
        if (ackC.size() >= 2) chk("rr/period", ackC[1] - ackC[0], S + E + H + 1);

        // Single write
        clrMon();
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h48;
        waitAck("single", 100, id, c);
        req0 = 1'b0;
        chk("single/id", 32'(id), 0);
        @(negedge clk);
        chk("single/ackPulse", 32'(ack0), 0);
        waitIdle("single", b);
        chk("single/busyLow", b - c, S + E + H);
        repeat (2) @(negedge clk);
        chk("single/pulses", riseC.size(), 1);
        if (riseC.size() == 1 && fallC.size() == 1) begin
            chk("single/enRise", riseC[0] - c, S);
            chk("single/enWidth", fallC[0] - riseC[0], E);
            chk("single/data", 32'(riseD[0]), 32'h48);
            chk("single/rs", 32'(riseR[0]), 1);
        end

        // Long wait for clear, normal wait for the same byte as a character
        clrMon();
        req1 = 1'b1; rs1 = 1'b0; data1 = 8'h01;
        waitAck("long", 100, id, c);
        req1 = 1'b0;
        chk("long/id", 32'(id), 1);
        waitIdle("long", b);
        if (fallC.size() == 1) chk("long/hold", b - fallC[0], L);
        clrMon();
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h01;
        waitAck("char01", 100, id, c);
        req1 = 1'b0;
        waitIdle("char01", b);
        if (fallC.size() == 1) chk("char01/hold", b - fallC[0], H);

        // Reset in the middle of an EN pulse, req0 still held
        clrMon();
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h55;
        waitAck("midrst", 100, id, c);
        enSeen = 1'b0;
        for (int i = 0; i < 20 && !enSeen; i++) begin
            @(negedge clk);
            if (lcd_en) enSeen = 1'b1;
        end
        chk("midrst/enSeen", 32'(enSeen), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst/lcd_en", 32'(lcd_en), 0);
        chk("midrst/busy", 32'(busy), 1);
        chk("midrst/init_done", 32'(init_done), 0);
        clrMon();
        r0 = cyc;
        rst_n = 1'b1;
        waitAck("midrst2", 300, id, c);
        chk("midrst/reId", 32'(id), 0);
        chk("midrst/reAckTime", c - r0, 73);
        req0 = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst/servedOnce", ackC.size(), 1);
        chk("midrst/pulses", riseC.size(), 5);
        if (riseC.size() == 5) chk("midrst/data", 32'(riseD[4]), 32'h55);

        // Request raised during init is held until the first IDLE edge
        rst_n = 1'b0;
        @(negedge clk);
        clrMon();
        r0 = cyc;
        rst_n = 1'b1;
        @(negedge clk);
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h7A;
        waitAck("initReq", 300, id, c);
        chk("initReq/id", 32'(id), 1);
        chk("initReq/afterDone", c - idRiseC, 1);
        chk("initReq/ackTime", c - r0, 73);
        req1 = 1'b0;
        waitIdle("initReq", b);
        chk("bus/enStable", enBad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
